// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive FIFO.
package uart_pkg;

  localparam int unsigned OVR_CNT_W               = 16;
  localparam int unsigned DEFAULT_BITS_DATA       = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH_LOG2 = 4;

  typedef logic [OVR_CNT_W-1:0] ovr_cnt_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read (distributed-RAM friendly).
module uart_fifo_mem #(
  parameter int unsigned Width     = 8,
  parameter int unsigned AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AddrWidth-1:0] wr_addr,
  input  logic [Width-1:0]     wr_data,
  input  logic [AddrWidth-1:0] rd_addr,
  output logic [Width-1:0]     rd_data
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: edge-detects rx_valid, buffers characters, flags drops.
// Optional overrun counter enabled by defining UART_RX_FIFO_OVR_CNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BITS_DATA       = DEFAULT_BITS_DATA,
  parameter int unsigned FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic [BITS_DATA-1:0]       rx_data,
  input  logic                       rx_valid,
  output logic [BITS_DATA-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DEPTH_LOG2:0]   fill,
  output logic                       full,
  output logic                       overrun,
  input  logic                       overrun_clr
`ifdef UART_RX_FIFO_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0]       overrun_cnt
`endif
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned FillW = FIFO_DEPTH_LOG2 + 1;
  localparam logic [FIFO_DEPTH_LOG2-1:0] PtrOne = 1;
  localparam logic [FillW-1:0] FillOne  = 1;
  localparam logic [FillW-1:0] FillFull = FillW'(Depth);

  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_addr;
  logic [FillW-1:0]           fill_q, fill_d, fill_after_pop;
  logic                       rx_valid_d;  // rx_valid delayed by one cycle
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;
  logic                       push, pop, wr_en, drop;

  assign full  = (fill_q == FillFull);
  assign push  = rx_valid && !rx_valid_d;
  assign pop   = out_valid_q && out_ready;
  assign wr_en = push && (!full || pop) && !reset;
  assign drop  = push && full && !pop;

  // Look ahead on pop so the next entry lands in the read register without a bubble.
  assign rd_addr = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

  // Entries written at this edge are not yet readable, so they do not count towards out_valid.
  assign fill_after_pop = pop ? fill_q - FillOne : fill_q;

  always_comb begin
    wr_ptr_d    = wr_en ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d    = rd_addr;
    out_valid_d = (fill_after_pop != '0);
    fill_d      = fill_q;
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + FillOne;
      2'b01:   fill_d = fill_q - FillOne;
      default: fill_d = fill_q;
    endcase
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      rx_valid_d  <= 1'b1;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      rx_valid_d  <= rx_valid;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_FIFO_OVR_CNT_EN
  ovr_cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && overrun_clr) begin
      cnt_d = ovr_cnt_t'(1);
    end else if (drop) begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + ovr_cnt_t'(1);
      end
    end else if (overrun_clr) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign overrun_cnt = cnt_q;
`endif

  uart_fifo_mem #(
    .Width     (BITS_DATA),
    .AddrWidth (FIFO_DEPTH_LOG2)
  ) u_mem (
    .clk     (sclk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (rx_data),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign fill      = fill_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default parameters, depth 16).
module tb_uart_rx_fifo;

  logic       sclk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] fill;
  logic       full;
  logic       overrun;
  logic       overrun_clr;
`ifdef UART_RX_FIFO_OVR_CNT_EN
  logic [15:0] overrun_cnt;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fifo dut (
    .sclk        (sclk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fill        (fill),
    .full        (full),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`ifdef UART_RX_FIFO_OVR_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 sclk = ~sclk;

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // One rising edge of rx_valid, then back low.
  task automatic push_char(input logic [7:0] c);
    rx_data  = c;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b0; overrun_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", out_data); end
`ifdef UART_RX_FIFO_OVR_CNT_EN
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", overrun_cnt); end
`endif
    // Pop on empty must be ignored.
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL empty_pop_fill got %0d exp 0", fill); end
  endtask

  task automatic test_level_hold();
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    tick();
    checks++; if (fill !== 5'd1) begin errors++; $display("FAIL hold_fill_write got %0d exp 1", fill); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL hold_data got %h exp a5", out_data); end
    for (int i = 0; i < 98; i++) tick();
    checks++; if (fill !== 5'd1) begin errors++; $display("FAIL hold_fill_after got %0d exp 1", fill); end
    rx_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL hold_pop_fill got %0d exp 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_pop_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) push_char(8'(i + 1));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fd_full got %b exp 1", full); end
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL fd_fill got %0d exp 16", fill); end
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL fd_head got %h exp 01", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(i + 1)) begin
        errors++;
        $display("FAIL fd_pop%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 8'(i + 1));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL fd_end_fill got %0d exp 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fd_end_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_char(8'(8'h20 + i));
    push_char(8'h55);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL ovr_fill got %0d exp 16", fill); end
`ifdef UART_RX_FIFO_OVR_CNT_EN
    checks++; if (overrun_cnt !== 16'd1) begin errors++; $display("FAIL ovr_cnt got %0d exp 1", overrun_cnt); end
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b exp 0", overrun); end
`ifdef UART_RX_FIFO_OVR_CNT_EN
    checks++; if (overrun_cnt !== 16'd0) begin errors++; $display("FAIL ovr_cnt_clr got %0d exp 0", overrun_cnt); end
`endif
    // Drop and clear in the same cycle: the drop wins.
    rx_data = 8'h66; rx_valid = 1'b1; overrun_clr = 1'b1;
    tick();
    rx_valid = 1'b0; overrun_clr = 1'b0;
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_prio got %b exp 1", overrun); end
`ifdef UART_RX_FIFO_OVR_CNT_EN
    checks++; if (overrun_cnt !== 16'd1) begin errors++; $display("FAIL ovr_cnt_prio got %0d exp 1", overrun_cnt); end
`endif
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h20 + i)) begin
        errors++;
        $display("FAIL ovr_pop%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, 8'(8'h20 + i));
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL ovr_end_fill got %0d exp 0", fill); end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 16; i++) push_char(8'(8'h30 + i));
    rx_data = 8'h77; rx_valid = 1'b1; out_ready = 1'b1;
    tick();
    rx_valid = 1'b0; out_ready = 1'b0;
    tick();
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL pp_fill got %0d exp 16", fill); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL pp_overrun got %b exp 0", overrun); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 15) ? 8'h77 : 8'(8'h31 + i);
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d) begin
        errors++;
        $display("FAIL pp_pop%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_d);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL pp_end_fill got %0d exp 0", fill); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_char(8'(8'h40 + i));
    checks++; if (fill !== 5'd5) begin errors++; $display("FAIL rm_fill_pre got %0d exp 5", fill); end
    rx_data = 8'h99; rx_valid = 1'b1; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL rm_fill got %0d exp 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", out_valid); end
    tick(); tick();
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL rm_no_push got %0d exp 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid got %b exp 0", out_valid); end
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 12; i++) push_char(8'(r * 12 + i));
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'(r * 12 + i)) begin
          errors++;
          $display("FAIL wrap_r%0d_i%0d got v=%b d=%h exp v=1 d=%h", r, i, out_valid, out_data,
                   8'(r * 12 + i));
        end
        tick();
      end
      out_ready = 1'b0;
    end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL wrap_end_fill got %0d exp 0", fill); end
  endtask

  initial begin
    test_reset();
    test_level_hold();
    test_fill_drain();
    test_overrun();
    test_push_pop_full();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
